// File: rtl/beam_mux_pkt.sv
// beam_mux_pkt: packet-aware AXI-stream demultiplexer.
// Routes the modulator stream to one of N_DACS DAC streams. The select is latched
// at packet start; out-of-range selects drop the packet and pulse sel_err.
// Each output has a 2-entry FIFO whose head register drives dac_t_* directly.
// Optional feature macro: BEAM_MUX_BCAST_EN adds the bcast input and the BCAST state,
// which copies every beat of the packet into all output FIFOs.
module beam_mux_pkt #(
    parameter int N_DACS = 4,
    parameter int DATA_W = 32,
    localparam int SEL_W = $clog2(N_DACS)
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef BEAM_MUX_BCAST_EN
    input  logic                     bcast,
`endif
    input  logic [SEL_W-1:0]         dac_sel,
    input  logic [DATA_W-1:0]        mod_t_data,
    input  logic                     mod_t_valid,
    output logic                     mod_t_ready,
    input  logic                     mod_t_last,
    output logic [N_DACS*DATA_W-1:0] dac_t_data,
    output logic [N_DACS-1:0]        dac_t_valid,
    input  logic [N_DACS-1:0]        dac_t_ready,
    output logic [N_DACS-1:0]        dac_t_last,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     busy,
    output logic                     sel_err
);

    // One extra bit so that N_DACS itself is representable for the range test.
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_DACS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DROP  = 2'd2
`ifdef BEAM_MUX_BCAST_EN
        ,ST_BCAST = 2'd3
`endif
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [SEL_W-1:0]   active_sel_r;
    logic               sel_err_r;
    logic               ready_s;
    logic               sel_ok_s;
    logic               bcast_s;
    logic [N_DACS-1:0]  push_s;
    logic [N_DACS-1:0]  full_s;

    assign sel_ok_s = ({1'b0, dac_sel} < N_LIM);
`ifdef BEAM_MUX_BCAST_EN
    assign bcast_s  = bcast;
`else
    assign bcast_s  = 1'b0;
`endif

    // Next-state, input ready and per-output push enables.
    always_comb begin
        state_s = state_r;
        ready_s = 1'b0;
        push_s  = '0;
        case (state_r)
            ST_IDLE: begin
                // The first beat is only inspected here, never consumed.
                if (mod_t_valid) begin
`ifdef BEAM_MUX_BCAST_EN
                    if (bcast_s) begin
                        state_s = ST_BCAST;
                    end else if (sel_ok_s) begin
                        state_s = ST_PASS;
                    end else begin
                        state_s = ST_DROP;
                    end
`else
                    if (sel_ok_s) begin
                        state_s = ST_PASS;
                    end else begin
                        state_s = ST_DROP;
                    end
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                ready_s = !full_s[active_sel_r];
                if (mod_t_valid && ready_s) begin
                    push_s[active_sel_r] = 1'b1;
                    if (mod_t_last) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_PASS;
                    end
                end else begin
                    state_s = ST_PASS;
                end
            end
            ST_DROP: begin
                ready_s = 1'b1;
                if (mod_t_valid && mod_t_last) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
`ifdef BEAM_MUX_BCAST_EN
            ST_BCAST: begin
                ready_s = ~|full_s;
                if (mod_t_valid && ready_s) begin
                    push_s = '1;
                    if (mod_t_last) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_BCAST;
                    end
                end else begin
                    state_s = ST_BCAST;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, latched select and the one-cycle select error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            active_sel_r <= '0;
            sel_err_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            sel_err_r <= (state_r == ST_IDLE) && mod_t_valid && !bcast_s && !sel_ok_s;
            if ((state_r == ST_IDLE) && mod_t_valid && bcast_s) begin
                active_sel_r <= '1;
            end else if ((state_r == ST_IDLE) && mod_t_valid && sel_ok_s) begin
                active_sel_r <= dac_sel;
            end else begin
                active_sel_r <= active_sel_r;
            end
        end
    end

    assign mod_t_ready = ready_s;
    assign active_sel  = active_sel_r;
    assign busy        = (state_r != ST_IDLE);
    assign sel_err     = sel_err_r;

    for (genvar i = 0; i < N_DACS; i++) begin : g_ch
        logic [DATA_W-1:0] head_r;
        logic [DATA_W-1:0] tail_r;
        logic              head_last_r;
        logic              tail_last_r;
        logic [1:0]        cnt_r;
        logic              pop_s;

        assign pop_s     = (cnt_r != 2'd0) && dac_t_ready[i];
        assign full_s[i] = (cnt_r == 2'd2);

        // Two-entry FIFO: head drives the port, tail refills head on a pop.
        always_ff @(posedge clk) begin
            if (rst) begin
                head_r      <= '0;
                tail_r      <= '0;
                head_last_r <= 1'b0;
                tail_last_r <= 1'b0;
                cnt_r       <= 2'd0;
            end else begin
                case (cnt_r)
                    2'd0: begin
                        if (push_s[i]) begin
                            head_r      <= mod_t_data;
                            head_last_r <= mod_t_last;
                            cnt_r       <= 2'd1;
                        end else begin
                            cnt_r <= 2'd0;
                        end
                    end
                    2'd1: begin
                        if (push_s[i] && pop_s) begin
                            head_r      <= mod_t_data;
                            head_last_r <= mod_t_last;
                        end else if (push_s[i]) begin
                            tail_r      <= mod_t_data;
                            tail_last_r <= mod_t_last;
                            cnt_r       <= 2'd2;
                        end else if (pop_s) begin
                            cnt_r <= 2'd0;
                        end else begin
                            cnt_r <= 2'd1;
                        end
                    end
                    2'd2: begin
                        if (pop_s) begin
                            head_r      <= tail_r;
                            head_last_r <= tail_last_r;
                            if (push_s[i]) begin
                                tail_r      <= mod_t_data;
                                tail_last_r <= mod_t_last;
                            end else begin
                                cnt_r <= 2'd1;
                            end
                        end else begin
                            cnt_r <= 2'd2;
                        end
                    end
                    default: begin
                        cnt_r <= 2'd0;
                    end
                endcase
            end
        end

        assign dac_t_data[i*DATA_W +: DATA_W] = head_r;
        assign dac_t_valid[i]                 = (cnt_r != 2'd0);
        assign dac_t_last[i]                  = head_last_r;
    end

endmodule

// File: tb/tb_beam_mux_pkt.sv
// Bench for beam_mux_pkt, built with N_DACS=3 so an out-of-range select is reachable.
// A queue-per-output model predicts every output beat from accepted input beats.
module tb_beam_mux_pkt;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [SW-1:0]   dac_sel;
    logic [DW-1:0]   mod_t_data;
    logic            mod_t_valid;
    logic            mod_t_ready;
    logic            mod_t_last;
    logic [N*DW-1:0] dac_t_data;
    logic [N-1:0]    dac_t_valid;
    logic [N-1:0]    dac_t_ready;
    logic [N-1:0]    dac_t_last;
    logic [SW-1:0]   active_sel;
    logic            busy;
    logic            sel_err;
`ifdef BEAM_MUX_BCAST_EN
    logic            bcast;
`endif

    int checks = 0;
    int passes = 0;

    // model state
    logic [DW:0] expq [N][$];
    bit          in_pkt = 1'b0;
    int          tgt = 0;
    int          exp_err = 0;
    int          seen_err = 0;
    int          n_beats [N];
    int          n_last [N];
    bit          prev_stall [N];
    logic [DW:0] prev_word [N];

    // ready pattern controls
    bit pat0  = 1'b0;
    bit hold1 = 1'b0;
    int cyc   = 0;

    beam_mux_pkt #(.N_DACS(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
`ifdef BEAM_MUX_BCAST_EN
        .bcast(bcast),
`endif
        .dac_sel(dac_sel), .mod_t_data(mod_t_data), .mod_t_valid(mod_t_valid),
        .mod_t_ready(mod_t_ready), .mod_t_last(mod_t_last),
        .dac_t_data(dac_t_data), .dac_t_valid(dac_t_valid), .dac_t_ready(dac_t_ready),
        .dac_t_last(dac_t_last), .active_sel(active_sel), .busy(busy), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Downstream ready generator: output 0 optionally follows 1,0,0,1; output 1 optionally held.
    initial begin
        dac_t_ready = '1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            dac_t_ready[0] = pat0 ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            dac_t_ready[1] = !hold1;
            dac_t_ready[2] = 1'b1;
        end
    end

    // Scoreboard: compare output handshakes against the model, then feed accepted input beats.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int i = 0; i < N; i++) begin
                expq[i].delete();
                prev_stall[i] = 1'b0;
            end
            in_pkt = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                logic [DW:0] w;
                w = {dac_t_last[i], dac_t_data[i*DW +: DW]};
                if (prev_stall[i])
                    check(dac_t_valid[i] === 1'b1 && w === prev_word[i], "hold_while_stalled", w, prev_word[i]);
                if (dac_t_valid[i] === 1'b1) begin
                    check(expq[i].size() != 0, "valid_without_data", 64'(i), 64'(expq[i].size()));
                    if (expq[i].size() != 0 && dac_t_ready[i] === 1'b1) begin
                        check(w === expq[i][0], "out_beat", w, expq[i][0]);
                        void'(expq[i].pop_front());
                        n_beats[i]++;
                        if (w[DW]) n_last[i]++;
                    end
                end
                prev_stall[i] = (dac_t_valid[i] === 1'b1) && (dac_t_ready[i] === 1'b0);
                prev_word[i]  = w;
            end
            if (sel_err === 1'b1) seen_err++;
            if (mod_t_valid === 1'b1 && mod_t_ready === 1'b1) begin
                if (!in_pkt) begin
                    in_pkt = 1'b1;
                    tgt = (int'(dac_sel) < N) ? int'(dac_sel) : -1;
`ifdef BEAM_MUX_BCAST_EN
                    if (bcast) tgt = N;
`endif
                    if (tgt < 0) exp_err++;
                end
                if (tgt == N) begin
                    for (int i = 0; i < N; i++) expq[i].push_back({mod_t_last, mod_t_data});
                end else if (tgt >= 0) begin
                    expq[tgt].push_back({mod_t_last, mod_t_data});
                end
                if (mod_t_last) in_pkt = 1'b0;
            end
        end
    end

    // Send one packet; optional select change at beat chg_at and reset at beat rst_at.
    task automatic send_pkt(input int sel, input int n, input int base, input int chg_at,
                            input int chg_sel, input int rst_at, input bit bc);
        bit acc;
        int t;
        dac_sel = sel[SW-1:0];
`ifdef BEAM_MUX_BCAST_EN
        bcast = bc;
`endif
        for (int b = 0; b < n; b++) begin
            if (b == rst_at) begin
                mod_t_valid = 1'b0;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            if (b == chg_at) dac_sel = chg_sel[SW-1:0];
            mod_t_data  = DW'(base + b);
            mod_t_last  = (b == n - 1);
            mod_t_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                acc = (mod_t_ready === 1'b1);
                @(posedge clk); #1;
                t++;
            end while (!acc && t < 200);
            check(acc, "accept_in_time", 64'(t), 64'(200));
            if (!acc) begin
                mod_t_valid = 1'b0;
                return;
            end
        end
        mod_t_valid = 1'b0;
        mod_t_last  = 1'b0;
`ifdef BEAM_MUX_BCAST_EN
        bcast = 1'b0;
`endif
    endtask

    // Wait until all outputs are empty, then confirm the model expects nothing more.
    task automatic drain();
        int t;
        bit empty;
        int left;
        t = 0;
        do begin
            @(negedge clk);
            empty = (dac_t_valid == '0);
            t++;
        end while (!empty && t < 1000);
        check(empty, "drain", 64'(dac_t_valid), 64'(0));
        left = 0;
        for (int i = 0; i < N; i++) left += expq[i].size();
        check(left == 0, "no_lost_beats", 64'(left), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int s0, s1, s2, l0, e0;
        for (int i = 0; i < N; i++) begin
            n_beats[i] = 0;
            n_last[i]  = 0;
        end
        rst = 1'b1; dac_sel = '0; mod_t_data = '0; mod_t_last = 1'b0; mod_t_valid = 1'b1;
`ifdef BEAM_MUX_BCAST_EN
        bcast = 1'b0;
`endif
        // 1: reset with valid held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(dac_t_valid == 3'b000, "rst_valid", 64'(dac_t_valid), 64'(0));
        check(mod_t_ready == 1'b0, "rst_ready", 64'(mod_t_ready), 64'(0));
        check(busy == 1'b0, "rst_busy", 64'(busy), 64'(0));
        check(sel_err == 1'b0 && active_sel == 2'd0, "rst_sel", {sel_err, active_sel}, 64'(0));
        check(dac_t_data == 96'd0 && dac_t_last == 3'b000, "rst_data", 64'(dac_t_data), 64'(0));
        @(posedge clk); #1;
        mod_t_valid = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // single-beat packet: IDLE bubble, then PASS, then IDLE
        dac_sel = 2'd0; mod_t_data = 32'h0000_5A5A; mod_t_last = 1'b1; mod_t_valid = 1'b1;
        @(negedge clk);
        check(busy == 1'b0 && mod_t_ready == 1'b0, "idle_bubble", {busy, mod_t_ready}, 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check(busy == 1'b1 && mod_t_ready == 1'b1 && active_sel == 2'd0, "pass_entered",
              {busy, mod_t_ready, active_sel}, 64'b1100);
        @(posedge clk); #1;
        mod_t_valid = 1'b0; mod_t_last = 1'b0;
        @(negedge clk);
        check(busy == 1'b0, "back_to_idle", 64'(busy), 64'(0));
        check(dac_t_valid[0] == 1'b1 && dac_t_data[31:0] == 32'h0000_5A5A && dac_t_last[0] == 1'b1,
              "single_beat_out", {dac_t_valid[0], dac_t_last[0], dac_t_data[31:0]}, 64'h3_0000_5A5A);
        @(posedge clk); #1;
        drain();

        // 2: 1024-beat ramp to output 2
        s0 = n_beats[0]; s1 = n_beats[1];
        send_pkt(2, 1024, 0, -1, 0, -1, 1'b0);
        drain();
        check(n_beats[2] == 1024 && n_last[2] == 1, "ramp_count", {32'(n_beats[2]), 32'(n_last[2])}, {32'd1024, 32'd1});
        check(n_beats[0] == s0 && n_beats[1] == s1, "ramp_others_quiet", 64'(n_beats[0] + n_beats[1]), 64'(s0 + s1));
        check(active_sel == 2'd2, "ramp_active_sel", 64'(active_sel), 64'(2));

        // 3: select change mid-packet is ignored; next packet follows the new select
        s1 = n_beats[1]; s2 = n_beats[2];
        send_pkt(1, 64, 32'h1000, 10, 2, -1, 1'b0);
        send_pkt(2, 16, 32'h2000, -1, 0, -1, 1'b0);
        drain();
        check(n_beats[1] - s1 == 64, "midsel_out1", 64'(n_beats[1] - s1), 64'(64));
        check(n_beats[2] - s2 == 16, "next_pkt_out2", 64'(n_beats[2] - s2), 64'(16));

        // 4: backpressure on output 0 while output 1 drains its backlog
        s0 = n_beats[0]; s1 = n_beats[1];
        hold1 = 1'b1;
        send_pkt(1, 2, 32'h3000, -1, 0, -1, 1'b0);
        pat0 = 1'b1; hold1 = 1'b0;
        send_pkt(0, 256, 32'h4000, -1, 0, -1, 1'b0);
        drain();
        pat0 = 1'b0;
        check(n_beats[0] - s0 == 256 && n_last[0] >= 1, "bp_out0", 64'(n_beats[0] - s0), 64'(256));
        check(n_beats[1] - s1 == 2, "bp_out1_drained", 64'(n_beats[1] - s1), 64'(2));

        // 5: out-of-range select drops the packet
        e0 = seen_err; s0 = n_beats[0] + n_beats[1] + n_beats[2];
        send_pkt(3, 16, 32'h5000, -1, 0, -1, 1'b0);
        drain();
        check(seen_err - e0 == 1, "sel_err_once", 64'(seen_err - e0), 64'(1));
        check(n_beats[0] + n_beats[1] + n_beats[2] == s0, "drop_no_output",
              64'(n_beats[0] + n_beats[1] + n_beats[2]), 64'(s0));

        // 6: reset mid-packet, then a fresh 8-beat packet to output 0
        send_pkt(1, 200, 32'h6000, -1, 0, 100, 1'b0);
        @(negedge clk);
        check(dac_t_valid == 3'b000 && busy == 1'b0, "flushed_by_reset", {dac_t_valid, busy}, 64'(0));
        @(posedge clk); #1;
        s0 = n_beats[0]; l0 = n_last[0]; s1 = n_last[1];
        send_pkt(0, 8, 32'h7000, -1, 0, -1, 1'b0);
        drain();
        check(n_beats[0] - s0 == 8 && n_last[0] - l0 == 1, "fresh_pkt", 64'(n_beats[0] - s0), 64'(8));
        check(n_last[1] == s1, "no_tlast_from_partial", 64'(n_last[1]), 64'(s1));
`ifdef BEAM_MUX_BCAST_EN
        s0 = n_beats[0]; s1 = n_beats[1]; s2 = n_beats[2];
        send_pkt(0, 8, 32'h8000, -1, 0, -1, 1'b1);
        drain();
        check(n_beats[0] - s0 == 8 && n_beats[1] - s1 == 8 && n_beats[2] - s2 == 8, "bcast_all",
              64'(n_beats[0] - s0 + n_beats[1] - s1 + n_beats[2] - s2), 64'(24));
`endif

        check(seen_err == exp_err && exp_err == 1, "sel_err_total", 64'(seen_err), 64'(1));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog so a wedged DUT still ends the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
